regfile_scoreboard: RTL
=======================

// Module: regfile_scoreboard
// PURPOSE
//  Next-generation integer register file: parametrised width, depth and port counts, plus a
//  per-register scoreboard (busy bits) for a pipelined/OoO-completion core.
//  - Decode reads operands and busy status through NUM_RD combinational ports.
//  - Issue marks destinations busy.
//  - NUM_WR writeback ports commit results and clear busy.
//  - A same-cycle write-to-read bypass removes the writeback->decode bubble.
// PARAMETERS
//  XLEN     64  data width of each register
//  NREGS    32  number of architectural registers; reg 0 hardwired to zero; AW=$clog2(NREGS)
//  NUM_RD    2  read ports
//  NUM_WR    2  writeback ports; higher index has priority
//  SP_IDX    2  register loaded from initial_sp during reset
// PORTS
//  clk          in   1            clock, all state updates on posedge
//  reset_n      in   1            asynchronous, active-low reset
//  initial_sp   in   XLEN         reset value for register SP_IDX
//  rs_addr      in   NUM_RD*AW    read addresses, port p at [p*AW +: AW]
//  rs_data      out  NUM_RD*XLEN  read data (bypassed)
//  rs_busy      out  NUM_RD       operand not yet available
//  issue_valid  in   1            mark issue_rd busy at next edge
//  issue_rd     in   AW           destination being issued
//  wb_valid     in   NUM_WR       writeback port valid
//  wb_rd        in   NUM_WR*AW    writeback destinations
//  wb_data      in   NUM_WR*XLEN  writeback data
//  flush        in   1            clear all busy bits (pipeline squash)
//  waw_err      out  1            sticky: issue to an already-busy register
//  abi_args     out  8*XLEN       a0..a7 (regs 10..17), a0 at [0 +: XLEN]; unbypassed
// BEHAVIOUR
//  Reset (reset_n=0, async):
//  - All regs 0 except reg SP_IDX = initial_sp (held while reset_n low).
//  - busy = 0, waw_err = 0.
//  Writes:
//  - At posedge, each port w with wb_valid[w] && wb_rd!=0 writes wb_data to reg wb_rd.
//  - Same rd on several ports: highest-index port wins.
//  - Writes to reg 0 are discarded.
//  Reads (combinational, 0 latency):
//  - rs_addr==0 -> data 0, busy 0.
//  - Else, if any valid wb port targets rs_addr this cycle -> that port's wb_data
//    (highest index wins) and busy=0.
//  - Else -> stored value and busy[rs_addr].
//  Scoreboard, next-state per reg r != 0 (busy[0] is constant 0):
//  - busy_n[r] = flush ? 0
//              : (issue_valid && issue_rd==r) ? 1
//              : (any wb_valid targeting r) ? 0
//              : busy[r].
//  - Issue wins over a same-cycle writeback to the same rd: the old producer retires,
//    the new producer is pending.
//  - flush does not block same-cycle writebacks; their data commits.
//  - flush wins over issue_valid (the squashed issue is not marked busy).
//  - issue_valid with issue_rd==0 is ignored.
//  waw_err:
//  - Set at posedge when issue_valid, issue_rd!=0, busy[issue_rd]=1, no same-cycle wb to
//    issue_rd, and flush=0.
//  - Cleared only by reset.
//  Writeback to a non-busy register:
//  - Legal, e.g. after flush; data commits and busy stays 0.
//  abi_args: reflects registered state only; new values appear the cycle after the write.
//  Reset mid-operation: immediate clear regardless of clk; pending wb/issue are lost.
// TESTING
//  1 Reset:
//    - initial_sp=0x8000_0000, reset_n low then high.
//    - Read reg 2 -> 0x8000_0000; regs 1,3..31 -> 0; all rs_busy=0; waw_err=0.
//  2 Bypass:
//    - wb_valid[0]=1, wb_rd[0]=5, wb_data[0]=0xDEAD, rs_addr[0]=5 in the same cycle.
//    - Same cycle: rs_data=0xDEAD, rs_busy=0. Next cycle: stored value = 0xDEAD.
//  3 Port priority:
//    - Ports 0 and 1 both write reg 7 with 0x11 / 0x22.
//    - Bypass and stored value both 0x22.
//    - wb to reg 0 with 0xFF: reads of reg 0 remain 0.
//  4 Scoreboard:
//    - issue reg 9 -> rs_busy=1 next cycle.
//    - wb reg 9 = 0x5 while issue reg 9 in the same cycle -> data 0x5, busy stays 1.
//    - Second wb reg 9 -> busy 0.
//  5 Flush/WAW:
//    - issue reg 4, then issue reg 4 again -> waw_err=1 (sticky).
//    - flush -> all busy 0.
//    - flush+issue reg 6 in the same cycle -> reg 6 not busy.
//  6 abi_args:
//    - wb reg 10 = 0x1234 -> abi_args[63:0] = 0x1234 one cycle after the edge.
//    - reset_n low mid-stream -> abi_args = 0 immediately.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register busy scoreboard, multi-port writeback,
// same-cycle writeback-to-read bypass and an unbypassed a0..a7 view.
module regfile_scoreboard #(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int SP_IDX = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [XLEN-1:0]            initial_sp,
    input  logic [NUM_RD*$clog2(NREGS)-1:0] rs_addr,
    output logic [NUM_RD*XLEN-1:0]     rs_data,
    output logic [NUM_RD-1:0]          rs_busy,
    input  logic                       issue_valid,
    input  logic [$clog2(NREGS)-1:0]   issue_rd,
    input  logic [NUM_WR-1:0]          wb_valid,
    input  logic [NUM_WR*$clog2(NREGS)-1:0] wb_rd,
    input  logic [NUM_WR*XLEN-1:0]     wb_data,
    input  logic                       flush,
    output logic                       waw_err,
    output logic [8*XLEN-1:0]          abi_args
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             waw_err_q;
    logic             waw_err_d;
    logic             issue_wb_hit;

    // Ports are walked in ascending order so the highest-index writer lands last.
    always_comb begin
        regs_d       = regs_q;
        busy_d       = busy_q;
        waw_err_d    = waw_err_q;
        issue_wb_hit = 1'b0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wb_valid[w] && (wb_rd[w*AW +: AW] != '0)) begin
                regs_d[wb_rd[w*AW +: AW]] = wb_data[w*XLEN +: XLEN];
                busy_d[wb_rd[w*AW +: AW]] = 1'b0;
                if (wb_rd[w*AW +: AW] == issue_rd) begin
                    issue_wb_hit = 1'b1;
                end
            end
        end
        if (issue_valid && (issue_rd != '0) && !flush) begin
            if (busy_q[issue_rd] && !issue_wb_hit) begin
                waw_err_d = 1'b1;
            end
            busy_d[issue_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    always_comb begin
        rs_data = '0;
        rs_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (rs_addr[p*AW +: AW] != '0) begin
                rs_data[p*XLEN +: XLEN] = regs_q[rs_addr[p*AW +: AW]];
                rs_busy[p]              = busy_q[rs_addr[p*AW +: AW]];
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wb_valid[w] && (wb_rd[w*AW +: AW] == rs_addr[p*AW +: AW])) begin
                        rs_data[p*XLEN +: XLEN] = wb_data[w*XLEN +: XLEN];
                        rs_busy[p]              = 1'b0;
                    end
                end
            end
        end
    end

    // The SP register tracks initial_sp for as long as reset is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == SP_IDX) ? initial_sp : '0;
            end
            busy_q    <= '0;
            waw_err_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            busy_q    <= busy_d;
            waw_err_q <= waw_err_d;
        end
    end

    assign waw_err = waw_err_q;

    for (genvar g = 0; g < 8; g++) begin : g_abi
        assign abi_args[g*XLEN +: XLEN] = regs_q[10+g];
    end

endmodule
